// File: rtl/finder_deser.sv
// finder_deser: serial-to-parallel feeder for finder A; optional parity via FINDER_DESER_PARITY_EN
module finder_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic [WIDTH-1:0]           word,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       overflow,
    output logic                       parity_err
);
    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {IDLE, COLLECT, PARITY} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sr, sr_nx, shifted, data;
    logic [CW-1:0]    cnt_nx;
    logic             done;
`ifdef FINDER_DESER_PARITY_EN
    logic             perr;
`endif

    assign shifted = MSB_FIRST ? {sr[WIDTH-2:0], bit_in} : {bit_in, sr[WIDTH-1:1]};

    // next-state: shift on valid bits, detect the completion edge
    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = bit_cnt;
        data     = shifted;
        done     = 1'b0;
`ifdef FINDER_DESER_PARITY_EN
        perr     = 1'b0;
        if (bit_valid) begin
            if (state == PARITY) begin
                done     = 1'b1;
                data     = sr;
                perr     = ^{sr, bit_in};
                cnt_nx   = '0;
                state_nx = IDLE;
            end else begin
                sr_nx    = shifted;
                cnt_nx   = bit_cnt + 1'b1;
                state_nx = (bit_cnt == CW'(WIDTH-1)) ? PARITY : COLLECT;
            end
        end
`else
        if (bit_valid) begin
            sr_nx = shifted;
            if (state == COLLECT && bit_cnt == CW'(WIDTH-1)) begin
                done     = 1'b1;
                cnt_nx   = '0;
                state_nx = IDLE;
            end else begin
                cnt_nx   = bit_cnt + 1'b1;
                state_nx = COLLECT;
            end
        end
`endif
    end

    // collection state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nx;
            sr      <= sr_nx;
            bit_cnt <= cnt_nx;
        end
    end

    // one-deep output buffer: load, drop with overflow, or consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word       <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (clr) begin
            word       <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (done && (!word_valid || word_ready)) begin
            word       <= data;
            word_valid <= 1'b1;
        end else if (done) begin
            overflow   <= 1'b1;
        end else if (word_ready) begin
            word_valid <= 1'b0;
        end
    end

`ifdef FINDER_DESER_PARITY_EN
    // sticky parity error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            parity_err <= 1'b0;
        else if (clr)
            parity_err <= 1'b0;
        else if (done && perr)
            parity_err <= 1'b1;
    end
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_finder_deser.sv
// tb_finder_deser: scoreboard bench for finder_deser (MSB-first and LSB-first instances)
module tb_finder_deser;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       word_ready = 1'b0;
    logic [7:0] word0, word1;
    logic       wv0, wv1, ov0, ov1, pe0, pe1;
    logic [3:0] cnt0, cnt1;

    int         total = 0;
    int         passed = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] exp;

    always #5 clk = ~clk;

    finder_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bit_in(bit_in), .bit_valid(bit_valid),
        .word(word0), .word_valid(wv0), .word_ready(word_ready), .bit_cnt(cnt0),
        .overflow(ov0), .parity_err(pe0)
    );

    finder_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bit_in(bit_in), .bit_valid(bit_valid),
        .word(word1), .word_valid(wv1), .word_ready(word_ready), .bit_cnt(cnt1),
        .overflow(ov1), .parity_err(pe1)
    );

    function automatic logic [7:0] rev(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        q0.push_back(w);
        q1.push_back(rev(w));
    endtask

    task automatic send_word(input logic [7:0] w, input int maxgap, input logic bad, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(maxgap)) tick();
            bit_in = w[7-i];
            bit_valid = 1'b1;
`ifndef FINDER_DESER_PARITY_EN
            word_ready = (i == 7) ? rdy_last : 1'b0;
`endif
            tick();
            bit_valid = 1'b0;
            word_ready = 1'b0;
        end
`ifdef FINDER_DESER_PARITY_EN
        bit_in = (^w) ^ bad;
        bit_valid = 1'b1;
        word_ready = rdy_last;
        tick();
        bit_valid = 1'b0;
        word_ready = 1'b0;
`else
        if (bad) bit_in = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        total++; if ({word0, wv0, cnt0, ov0, pe0} !== 15'd0) $display("FAIL reset u0 got %h required 0", {word0, wv0, cnt0, ov0, pe0}); else passed++;
        total++; if ({word1, wv1, cnt1, ov1, pe1} !== 15'd0) $display("FAIL reset u1 got %h required 0", {word1, wv1, cnt1, ov1, pe1}); else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_msb_lsb();
        push(8'hAA);
        send_word(8'hAA, 0, 1'b0, 1'b0);
        exp = q0.pop_front();
        total++; if (word0 !== exp) $display("FAIL msb_word got %h required %h", word0, exp); else passed++;
        total++; if (wv0 !== 1'b1) $display("FAIL msb_valid got %b required 1", wv0); else passed++;
        total++; if (cnt0 !== 4'd0) $display("FAIL msb_cnt got %0d required 0", cnt0); else passed++;
        exp = q1.pop_front();
        total++; if (word1 !== exp) $display("FAIL lsb_word got %h required %h", word1, exp); else passed++;
    endtask

    task automatic test_ready();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        total++; if (wv1 !== 1'b0) $display("FAIL ready_valid got %b required 0", wv1); else passed++;
        total++; if (word1 !== 8'h55) $display("FAIL ready_hold got %h required 55", word1); else passed++;
        tick();
        total++; if (wv0 !== 1'b0) $display("FAIL ready_ignored got %b required 0", wv0); else passed++;
    endtask

    task automatic test_gaps();
        logic [7:0] w;
        w = 8'h0F;
        push(w);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(5)) tick();
            total++; if (cnt0 !== 4'(i)) $display("FAIL gap_hold[%0d] got %0d required %0d", i, cnt0, i); else passed++;
            bit_in = w[7-i];
            bit_valid = 1'b1;
            tick();
            bit_valid = 1'b0;
            if (i < 7) begin
                total++; if (cnt0 !== 4'(i + 1)) $display("FAIL gap_cnt[%0d] got %0d required %0d", i, cnt0, i + 1); else passed++;
            end
        end
`ifdef FINDER_DESER_PARITY_EN
        total++; if (cnt0 !== 4'd8) $display("FAIL gap_par_cnt got %0d required 8", cnt0); else passed++;
        bit_in = ^w;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
`endif
        exp = q0.pop_front();
        void'(q1.pop_front());
        total++; if (word0 !== exp || wv0 !== 1'b1) $display("FAIL gap_word got %h/%b required %h/1", word0, wv0, exp); else passed++;
        total++; if (cnt0 !== 4'd0) $display("FAIL gap_end_cnt got %0d required 0", cnt0); else passed++;
    endtask

    task automatic test_overflow();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        push(8'hAA);
        send_word(8'hAA, 2, 1'b0, 1'b0);
        total++; if (ov0 !== 1'b0) $display("FAIL ovf_early got %b required 0", ov0); else passed++;
        send_word(8'h01, 2, 1'b0, 1'b0);
        exp = q0.pop_front();
        void'(q1.pop_front());
        total++; if (word0 !== exp) $display("FAIL ovf_word got %h required %h", word0, exp); else passed++;
        total++; if (ov0 !== 1'b1 || wv0 !== 1'b1) $display("FAIL ovf_flag got %b/%b required 1/1", ov0, wv0); else passed++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++; if ({word0, wv0, cnt0, ov0, pe0} !== 15'd0) $display("FAIL clr got %h required 0", {word0, wv0, cnt0, ov0, pe0}); else passed++;
    endtask

    task automatic test_back_to_back();
        push(8'hAA);
        send_word(8'hAA, 1, 1'b0, 1'b0);
        exp = q0.pop_front();
        void'(q1.pop_front());
        total++; if (word0 !== exp) $display("FAIL b2b_first got %h required %h", word0, exp); else passed++;
        push(8'h80);
        send_word(8'h80, 1, 1'b0, 1'b1);
        exp = q0.pop_front();
        total++; if (word0 !== exp || wv0 !== 1'b1) $display("FAIL b2b_word got %h/%b required %h/1", word0, wv0, exp); else passed++;
        exp = q1.pop_front();
        total++; if (word1 !== exp) $display("FAIL b2b_lsb got %h required %h", word1, exp); else passed++;
        total++; if (ov0 !== 1'b0) $display("FAIL b2b_ovf got %b required 0", ov0); else passed++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            bit_in = 1'b1;
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        total++; if (cnt0 !== 4'd4) $display("FAIL mid_cnt got %0d required 4", cnt0); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (cnt0 !== 4'd0 || wv0 !== 1'b0) $display("FAIL async_rst got %0d/%b required 0/0", cnt0, wv0); else passed++;
        tick();
        rst_n = 1'b1;
        tick();
        push(8'h3C);
`ifdef FINDER_DESER_PARITY_EN
        send_word(8'h3C, 1, 1'b1, 1'b0);
        total++; if (pe0 !== 1'b1) $display("FAIL par_err got %b required 1", pe0); else passed++;
`else
        send_word(8'h3C, 1, 1'b0, 1'b0);
        total++; if (pe0 !== 1'b0) $display("FAIL par_tied got %b required 0", pe0); else passed++;
`endif
        exp = q0.pop_front();
        total++; if (word0 !== exp || wv0 !== 1'b1) $display("FAIL residue_word got %h/%b required %h/1", word0, wv0, exp); else passed++;
        exp = q1.pop_front();
        total++; if (word1 !== exp) $display("FAIL residue_lsb got %h required %h", word1, exp); else passed++;
    endtask

    initial begin
        test_reset();
        test_msb_lsb();
        test_ready();
        test_gaps();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
